// File: rtl/ysyx_25020051_arb_pkg.sv
// Shared types for the IFU/LSU memory arbiter: FSM states, owner encoding, default widths.
package ysyx_25020051_arb_pkg;
  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;
endpackage

// File: rtl/ysyx_25020051_MuxKey.sv
// Keyed multiplexer: lut_i holds NR_KEY {key, data} pairs, entry 0 in the low bits.
module ysyx_25020051_MuxKey #(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1
) (
  output logic [DATA_LEN-1:0]                  out_o,
  input  logic [KEY_LEN-1:0]                   key_i,
  input  logic [DATA_LEN-1:0]                  default_i,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut_i
);
  localparam int PAIR_LEN = KEY_LEN + DATA_LEN;

  always_comb begin
    out_o = default_i;
    for (int i = 0; i < NR_KEY; i++) begin
      if (lut_i[i*PAIR_LEN+DATA_LEN +: KEY_LEN] == key_i) out_o = lut_i[i*PAIR_LEN +: DATA_LEN];
    end
  end
endmodule

// File: rtl/ysyx_25020051_arb_pick.sv
// Winner selection. YSYX_25020051_ARB_ROUND_ROBIN_EN selects round-robin; default is LSU-first priority.
module ysyx_25020051_arb_pick
  import ysyx_25020051_arb_pkg::*;
(
  input  logic   m0_valid_i,
  input  logic   m1_valid_i,
  input  owner_e last_grant_i,
  output owner_e winner_o
);
`ifdef YSYX_25020051_ARB_ROUND_ROBIN_EN
  always_comb begin
    if (m0_valid_i && m1_valid_i) winner_o = (last_grant_i == OWN_LSU) ? OWN_IFU : OWN_LSU;
    else                          winner_o = m1_valid_i ? OWN_LSU : OWN_IFU;
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
  assign winner_o = m1_valid_i ? OWN_LSU : OWN_IFU;
`endif
endmodule

// File: rtl/ysyx_25020051_mem_arbiter.sv
// Two-master (IFU/LSU) to one-slave memory arbiter, one transaction outstanding.
// Optional round-robin selection via YSYX_25020051_ARB_ROUND_ROBIN_EN (see arb_pick).
module ysyx_25020051_mem_arbiter
  import ysyx_25020051_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req_valid,
  output logic                m0_req_ready,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic                m0_wen,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wmask,
  output logic                m0_resp_valid,
  input  logic                m0_resp_ready,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req_valid,
  output logic                m1_req_ready,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic                m1_wen,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wmask,
  output logic                m1_resp_valid,
  input  logic                m1_resp_ready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                s_req_valid,
  input  logic                s_req_ready,
  output logic [ADDR_W-1:0]   s_addr,
  output logic                s_wen,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wmask,
  input  logic                s_resp_valid,
  output logic                s_resp_ready,
  input  logic [DATA_W-1:0]   s_rdata
);
  localparam int MW = DATA_W / 8;
  localparam int BW = ADDR_W + DATA_W + MW + 3;

  arb_state_e state_q, state_d;
  owner_e     owner_q, owner_d;
  owner_e     last_grant_q, last_grant_d;
  owner_e     winner;

  logic [BW-1:0]     own_bus;
  logic [1:0]        own_sel;
  logic              own_req_valid, own_resp_ready, own_wen;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;
  logic [MW-1:0]     own_wmask;
  logic              in_req, in_resp;

  ysyx_25020051_arb_pick u_pick (
    .m0_valid_i  (m0_req_valid),
    .m1_valid_i  (m1_req_valid),
    .last_grant_i(last_grant_q),
    .winner_o    (winner)
  );

  // Owner's live request bundle, including its resp_ready for the response phase.
  ysyx_25020051_MuxKey #(.NR_KEY(2), .KEY_LEN(1), .DATA_LEN(BW)) u_req_mux (
    .out_o    (own_bus),
    .key_i    (owner_q),
    .default_i('0),
    .lut_i    ({1'b1, m1_req_valid, m1_resp_ready, m1_addr, m1_wen, m1_wdata, m1_wmask,
                1'b0, m0_req_valid, m0_resp_ready, m0_addr, m0_wen, m0_wdata, m0_wmask})
  );

  ysyx_25020051_MuxKey #(.NR_KEY(2), .KEY_LEN(1), .DATA_LEN(2)) u_sel_mux (
    .out_o    (own_sel),
    .key_i    (owner_q),
    .default_i(2'b00),
    .lut_i    ({1'b1, 2'b10, 1'b0, 2'b01})
  );

  assign {own_req_valid, own_resp_ready, own_addr, own_wen, own_wdata, own_wmask} = own_bus;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_IFU;
      last_grant_q <= OWN_LSU;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_req_valid || m1_req_valid) begin
          owner_d = winner;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!own_req_valid)   state_d = ST_IDLE;
        else if (s_req_ready) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (s_resp_valid && own_resp_ready) begin
          state_d      = ST_IDLE;
          last_grant_d = owner_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_req  = (state_q == ST_REQ);
  assign in_resp = (state_q == ST_RESP);

  assign s_req_valid  = in_req & own_req_valid;
  assign s_addr       = in_req ? own_addr  : '0;
  assign s_wen        = in_req & own_wen;
  assign s_wdata      = in_req ? own_wdata : '0;
  assign s_wmask      = in_req ? own_wmask : '0;
  assign m0_req_ready = in_req & own_sel[0] & s_req_ready;
  assign m1_req_ready = in_req & own_sel[1] & s_req_ready;

  // Stray slave responses outside RESP are neither forwarded nor acknowledged.
  assign s_resp_ready  = in_resp & own_resp_ready;
  assign m0_resp_valid = in_resp & own_sel[0] & s_resp_valid;
  assign m1_resp_valid = in_resp & own_sel[1] & s_resp_valid;
  assign m0_rdata      = (in_resp & own_sel[0]) ? s_rdata : '0;
  assign m1_rdata      = (in_resp & own_sel[1]) ? s_rdata : '0;
endmodule

// File: tb/tb_ysyx_25020051_mem_arbiter.sv
// Bench for ysyx_25020051_mem_arbiter: vector table, corner-case sequences, random traffic vs. a transaction model.
module tb_ysyx_25020051_mem_arbiter;
`ifdef YSYX_25020051_ARB_ROUND_ROBIN_EN
  localparam bit F = 1'b0;
`else
  localparam bit F = 1'b1;
`endif

  typedef struct packed {
    logic        rst;
    logic        m0_v;
    logic [31:0] m0_addr;
    logic        m0_wen;
    logic [31:0] m0_wdata;
    logic [3:0]  m0_wmask;
    logic        m0_rr;
    logic        m1_v;
    logic [31:0] m1_addr;
    logic        m1_wen;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_wmask;
    logic        m1_rr;
    logic        s_rdy;
    logic        s_rv;
    logic [31:0] s_rdata;
  } in_t;

  typedef struct packed {
    logic        m0_req_ready;
    logic        m0_resp_valid;
    logic [31:0] m0_rdata;
    logic        m1_req_ready;
    logic        m1_resp_valid;
    logic [31:0] m1_rdata;
    logic        s_req_valid;
    logic [31:0] s_addr;
    logic        s_wen;
    logic [31:0] s_wdata;
    logic [3:0]  s_wmask;
    logic        s_resp_ready;
  } out_t;

  typedef struct packed {
    logic [6:0] in;
    logic [5:0] eh;
    logic [1:0] esrc;
    logic [1:0] erd;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t  vin = '0;
  out_t got;
  logic m0_req_ready, m0_resp_valid, m1_req_ready, m1_resp_valid;
  logic s_req_valid, s_wen, s_resp_ready;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic [3:0]  s_wmask;

  ysyx_25020051_mem_arbiter dut (
    .clk(clk), .rst(vin.rst),
    .m0_req_valid(vin.m0_v), .m0_req_ready(m0_req_ready), .m0_addr(vin.m0_addr),
    .m0_wen(vin.m0_wen), .m0_wdata(vin.m0_wdata), .m0_wmask(vin.m0_wmask),
    .m0_resp_valid(m0_resp_valid), .m0_resp_ready(vin.m0_rr), .m0_rdata(m0_rdata),
    .m1_req_valid(vin.m1_v), .m1_req_ready(m1_req_ready), .m1_addr(vin.m1_addr),
    .m1_wen(vin.m1_wen), .m1_wdata(vin.m1_wdata), .m1_wmask(vin.m1_wmask),
    .m1_resp_valid(m1_resp_valid), .m1_resp_ready(vin.m1_rr), .m1_rdata(m1_rdata),
    .s_req_valid(s_req_valid), .s_req_ready(vin.s_rdy), .s_addr(s_addr), .s_wen(s_wen),
    .s_wdata(s_wdata), .s_wmask(s_wmask), .s_resp_valid(vin.s_rv),
    .s_resp_ready(s_resp_ready), .s_rdata(vin.s_rdata)
  );

  assign got = {m0_req_ready, m0_resp_valid, m0_rdata, m1_req_ready, m1_resp_valid, m1_rdata,
                s_req_valid, s_addr, s_wen, s_wdata, s_wmask, s_resp_ready};

  // Transaction model: is a transfer in flight, whose is it, has the slave taken the request.
  bit m_busy, m_acc, m_own, m_last;
  int n_pass = 0, n_total = 0;

  task automatic check(input string name, input logic [159:0] g, input logic [159:0] e);
    n_total++;
    if (g === e) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, g, e);
  endtask

  function automatic out_t model_out(input in_t i);
    out_t o;
    o = '0;
    if (m_busy && !m_acc) begin
      o.s_req_valid = m_own ? i.m1_v     : i.m0_v;
      o.s_addr      = m_own ? i.m1_addr  : i.m0_addr;
      o.s_wen       = m_own ? i.m1_wen   : i.m0_wen;
      o.s_wdata     = m_own ? i.m1_wdata : i.m0_wdata;
      o.s_wmask     = m_own ? i.m1_wmask : i.m0_wmask;
      if (m_own) o.m1_req_ready = i.s_rdy;
      else       o.m0_req_ready = i.s_rdy;
    end else if (m_busy) begin
      o.s_resp_ready = m_own ? i.m1_rr : i.m0_rr;
      if (m_own) begin o.m1_resp_valid = i.s_rv; o.m1_rdata = i.s_rdata; end
      else       begin o.m0_resp_valid = i.s_rv; o.m0_rdata = i.s_rdata; end
    end
    return o;
  endfunction

  task automatic model_step(input in_t i);
    if (i.rst) begin
      m_busy = 0; m_acc = 0; m_own = 0; m_last = 1;
    end else if (!m_busy) begin
      if (i.m0_v || i.m1_v) begin
        m_busy = 1; m_acc = 0;
        if (i.m0_v && i.m1_v) m_own = F ? 1'b1 : !m_last;
        else                  m_own = i.m1_v;
      end
    end else if (!m_acc) begin
      if (!(m_own ? i.m1_v : i.m0_v)) m_busy = 0;
      else if (i.s_rdy)               m_acc = 1;
    end else if (i.s_rv && (m_own ? i.m1_rr : i.m0_rr)) begin
      m_busy = 0; m_last = m_own;
    end
  endtask

  task automatic cyc(input in_t i, input string name);
    @(negedge clk);
    vin = i;
    #1;
    check(name, 160'(got), 160'(model_out(i)));
    model_step(i);
  endtask

  // bits: {rst, m0_v, m1_v, s_rdy, s_rv, m0_rr, m1_rr}; m0 reads 0x80000000, m1 writes 0x12345678 to 0x10
  function automatic in_t mk(input logic [6:0] b);
    in_t i;
    i = '0;
    {i.rst, i.m0_v, i.m1_v, i.s_rdy, i.s_rv, i.m0_rr, i.m1_rr} = b;
    i.m0_addr  = 32'h8000_0000;
    i.m1_addr  = 32'h0000_0010;
    i.m1_wen   = 1'b1;
    i.m1_wdata = 32'h1234_5678;
    i.m1_wmask = 4'hF;
    i.s_rdata  = 32'hDEAD_BEEF;
    return i;
  endfunction

  vec_t tbl[$];
  logic [31:0] ea;

  initial begin
    tbl.push_back('{7'b0000000, 6'b000000, 2'd0, 2'b00});
    tbl.push_back('{7'b0000100, 6'b000000, 2'd0, 2'b00});
    tbl.push_back('{7'b0101011, 6'b000000, 2'd0, 2'b00});
    tbl.push_back('{7'b0101011, 6'b101000, 2'd1, 2'b00});
    tbl.push_back('{7'b0000111, 6'b000101, 2'd0, 2'b10});
    tbl.push_back('{7'b0000000, 6'b000000, 2'd0, 2'b00});
    tbl.push_back('{7'b1000000, 6'b000000, 2'd0, 2'b00});
    tbl.push_back('{7'b0110011, 6'b000000, 2'd0, 2'b00});
    tbl.push_back('{7'b0111011, {!F, F, 4'b1000}, {F, !F}, 2'b00});
    tbl.push_back('{{1'b0, F, !F, 4'b0111}, {3'b000, !F, F, 1'b1}, 2'd0, {!F, F}});
    tbl.push_back('{{1'b0, F, !F, 4'b0011}, 6'b000000, 2'd0, 2'b00});
    tbl.push_back('{{1'b0, F, !F, 4'b1011}, {F, !F, 4'b1000}, {!F, F}, 2'b00});
    tbl.push_back('{7'b0000111, {3'b000, F, !F, 1'b1}, 2'd0, {F, !F}});
    tbl.push_back('{7'b0000000, 6'b000000, 2'd0, 2'b00});

    vin = mk(7'b1000000);
    repeat (2) @(posedge clk);
    model_step(vin);

    for (int k = 0; k < tbl.size(); k++) begin
      cyc(mk(tbl[k].in), $sformatf("vec%0d_model", k));
      ea = (tbl[k].esrc == 2'd1) ? 32'h8000_0000 : (tbl[k].esrc == 2'd2) ? 32'h10 : 32'h0;
      check($sformatf("vec%0d", k),
            160'({m0_req_ready, m1_req_ready, s_req_valid, m0_resp_valid, m1_resp_valid,
                  s_resp_ready, s_addr, m0_rdata, m1_rdata}),
            160'({tbl[k].eh, ea, tbl[k].erd[1] ? 32'hDEAD_BEEF : 32'h0,
                  tbl[k].erd[0] ? 32'hDEAD_BEEF : 32'h0}));
    end

    // Slave stalls the LSU write; payload must hold and the IFU must wait.
    cyc(mk(7'b0010000), "h035_grant");
    for (int k = 0; k < 4; k++) begin
      cyc(mk(7'b0110000), "h035_stall");
      check("h035_payload",
            160'({s_req_valid, s_addr, s_wen, s_wdata, s_wmask, m1_req_ready, m0_req_ready}),
            160'({1'b1, 32'h10, 1'b1, 32'h1234_5678, 4'hF, 1'b0, 1'b0}));
    end
    cyc(mk(7'b0111000), "h035_accept");
    check("h035_ready", 160'({m1_req_ready, m0_req_ready}), 160'(2'b10));
    cyc(mk(7'b0100101), "h035_resp");
    check("h035_rdata", 160'({m1_resp_valid, m1_rdata, s_resp_ready}), 160'({1'b1, 32'hDEAD_BEEF, 1'b1}));

    // IFU holds off its response for three cycles.
    cyc(mk(7'b0100000), "h036_grant");
    cyc(mk(7'b0101000), "h036_req");
    check("h036_req_ready", 160'(m0_req_ready), 160'(1'b1));
    for (int k = 0; k < 3; k++) begin
      cyc(mk(7'b0000100), "h036_hold");
      check("h036_hold_rdy", 160'({s_resp_ready, m0_resp_valid}), 160'(2'b01));
    end
    cyc(mk(7'b0000110), "h036_done");
    check("h036_done", 160'({s_resp_ready, m0_resp_valid, m0_rdata}), 160'({2'b11, 32'hDEAD_BEEF}));
    cyc(mk(7'b0100000), "h036_idle");
    check("h036_idle", 160'({m0_req_ready, s_req_valid, m0_resp_valid, s_resp_ready}), 160'(4'b0000));

    // Reset lands in RESP; the next request must be served normally.
    cyc(mk(7'b0101000), "h037_req");
    cyc(mk(7'b1000010), "h037_rst");
    cyc(mk(7'b0100110), "h037_after");
    check("h037_all_zero", 160'(got), 160'(0));
    cyc(mk(7'b0101000), "h037_regrant");
    check("h037_regrant", 160'({m0_req_ready, s_addr}), 160'({1'b1, 32'h8000_0000}));
    cyc(mk(7'b0000110), "h037_resp");
    check("h037_resp", 160'({m0_resp_valid, m0_rdata}), 160'({1'b1, 32'hDEAD_BEEF}));

    for (int k = 0; k < 400; k++) begin
      in_t r;
      r.rst      = ($urandom_range(0, 49) == 0);
      r.m0_v     = ($urandom_range(0, 2) != 0);
      r.m0_addr  = $urandom;
      r.m0_wen   = $urandom_range(0, 1);
      r.m0_wdata = $urandom;
      r.m0_wmask = 4'($urandom_range(0, 15));
      r.m0_rr    = ($urandom_range(0, 3) != 0);
      r.m1_v     = ($urandom_range(0, 2) != 0);
      r.m1_addr  = $urandom;
      r.m1_wen   = $urandom_range(0, 1);
      r.m1_wdata = $urandom;
      r.m1_wmask = 4'($urandom_range(0, 15));
      r.m1_rr    = ($urandom_range(0, 3) != 0);
      r.s_rdy    = $urandom_range(0, 1);
      r.s_rv     = $urandom_range(0, 1);
      r.s_rdata  = $urandom;
      cyc(r, $sformatf("rand%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
